wbh_clken_gen: RTL

WBH_CLKEN_GEN -- requirements
Module: wbh_clken_gen

---
 rtl/wbh_clken_gen.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wbh_clken_gen.sv
// ----------------------------------------------------------------------------
// wbh_clken_gen
//
// Programmable multi-channel clock-enable generator. Each channel divides
// mclk by (R+1), where R is an unsigned DIV_W-bit ratio. It produces:
//   - a one-cycle clk_en pulse on every terminal count, and
//   - an optional square wave clk_tgl that inverts on every terminal count.
// Ratio changes made while a channel runs are held in a shadow register.
// They are applied at the next terminal count, so a period is never cut
// short or stretched mid-count.
//
// Register map (word addresses):
//   0x0      GLB_CTRL  [NUM_CH-1:0] ch_en, [8+NUM_CH-1:8] tgl_mode,
//                      [16] restart (write-1 pulse, reads 0)
//   0x1      STATUS    [NUM_CH-1:0] channel running, [8+NUM_CH-1:8] pending
//   0x2+i    DIV_i     [DIV_W-1:0] shadow ratio of channel i
//   others   read 0, writes ignored (still acknowledged)
//
// Ports:
//   mclk       in   sole clock, rising edge
//   reset      in   asynchronous active-high reset
//   reg_cs     in   register access request
//   reg_wr     in   1 = write, 0 = read
//   reg_addr   in   word address [3:0]
//   reg_wdata  in   write data [31:0]
//   reg_be     in   byte enables [3:0]
//   reg_rdata  out  registered read data, held until the next read
//   reg_ack    out  one-cycle acknowledge, one cycle after the request
//   clk_en     out  per-channel one-cycle enable pulse [NUM_CH-1:0]
//   clk_tgl    out  per-channel toggle output [NUM_CH-1:0]
// ----------------------------------------------------------------------------
module wbh_clken_gen #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 1
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              reg_cs,
    input  logic              reg_wr,
    input  logic [3:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    input  logic [3:0]        reg_be,
    output logic [31:0]       reg_rdata,
    output logic              reg_ack,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_tgl
);

    localparam logic [3:0]       ADDR_GLB    = 4'h0;
    localparam logic [3:0]       ADDR_STATUS = 4'h1;
    localparam logic [DIV_W-1:0] RATIO_RST   = DIV_W'(DIV_RST);

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

    // Byte-enable merge of a write into a ratio register.
    function automatic logic [DIV_W-1:0] merge_div(
        input logic [DIV_W-1:0] cur,
        input logic [DIV_W-1:0] wd,
        input logic [DIV_W-1:0] mask
    );
        return (cur & ~mask) | (wd & mask);
    endfunction

    // ------------------------------------------------------------------
    // Register interface
    // ------------------------------------------------------------------
    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d;
    logic [NUM_CH-1:0] tgl_mode_q, tgl_mode_d;

    logic              access;
    logic              wr_stb;
    logic              rd_stb;
    logic              glb_wr;
    logic              restart;
    logic [DIV_W-1:0]  div_bmask;
    logic [31:0]       rd_val;

    // Per-channel views gathered for the read mux and the outputs.
    logic [NUM_CH-1:0] run_vec;
    logic [NUM_CH-1:0] pend_vec;
    logic [DIV_W-1:0]  shd_arr [NUM_CH];

    // Parts of the bus that no register field happens to use.
    logic              unused_bus;
    assign unused_bus = ^{reg_wdata, reg_be};

    // A request is taken only while ack is low, so a held reg_cs
    // produces alternating single-cycle acknowledges, never a stuck one.
    assign access  = reg_cs && !ack_q;
    assign wr_stb  = access && reg_wr;
    assign rd_stb  = access && !reg_wr;
    assign glb_wr  = wr_stb && (reg_addr == ADDR_GLB);
    assign restart = glb_wr && reg_be[2] && reg_wdata[16];

    always_comb begin
        div_bmask = '0;
        for (int b = 0; b < DIV_W; b++) begin
            div_bmask[b] = reg_be[b / 8];
        end
    end

    always_comb begin
        ch_en_d    = ch_en_q;
        tgl_mode_d = tgl_mode_q;
        if (glb_wr) begin
            if (reg_be[0]) begin
                ch_en_d = reg_wdata[NUM_CH-1:0];
            end
            if (reg_be[1]) begin
                tgl_mode_d = reg_wdata[8 +: NUM_CH];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (reg_addr == ADDR_GLB) begin
            rd_val[NUM_CH-1:0]  = ch_en_q;
            rd_val[8 +: NUM_CH] = tgl_mode_q;
        end else if (reg_addr == ADDR_STATUS) begin
            rd_val[NUM_CH-1:0]  = run_vec;
            rd_val[8 +: NUM_CH] = pend_vec;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (reg_addr == 4'(k + 2)) begin
                    rd_val = 32'(shd_arr[k]);
                end
            end
        end
    end

    assign ack_d   = access;
    assign rdata_d = rd_stb ? rd_val : rdata_q;

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            ch_en_q    <= '0;
            tgl_mode_q <= '0;
        end else begin
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ch_en_q    <= ch_en_d;
            tgl_mode_q <= tgl_mode_d;
        end
    end

    assign reg_ack   = ack_q;
    assign reg_rdata = rdata_q;

    // ------------------------------------------------------------------
    // Divider channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [3:0] CH_ADDR = 4'(i + 2);

        ch_state_e        state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] act_q, act_d;
        logic [DIV_W-1:0] shd_q, shd_d;
        logic             pend_q, pend_d;
        logic             en_q, en_d;
        logic             tgl_q, tgl_d;
        logic             div_wr;
        logic [DIV_W-1:0] wval;

        assign div_wr = wr_stb && (reg_addr == CH_ADDR);
        assign wval   = merge_div(shd_q, reg_wdata[DIV_W-1:0], div_bmask);

        // Invariant: whenever pending is clear, shadow equals active. That
        // lets every reload point simply take the (possibly just written)
        // shadow value.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            act_d   = act_q;
            shd_d   = div_wr ? wval : shd_q;
            pend_d  = pend_q;
            en_d    = 1'b0;
            tgl_d   = tgl_q;

            unique case (state_q)
                CH_IDLE: begin
                    cnt_d  = '0;
                    tgl_d  = 1'b0;
                    act_d  = shd_d;
                    pend_d = 1'b0;
                    if (ch_en_d[i]) begin
                        state_d = CH_RUN;
                        cnt_d   = shd_d;
                    end
                end

                CH_RUN: begin
                    if (!ch_en_d[i]) begin
                        // Stop at this edge; any deferred ratio becomes
                        // active so the next enable uses the latest value.
                        state_d = CH_IDLE;
                        cnt_d   = '0;
                        tgl_d   = 1'b0;
                        act_d   = shd_d;
                        pend_d  = 1'b0;
                    end else if (restart) begin
                        // Phase-align: every running channel restarts its
                        // count from the shadow ratio on the same edge.
                        cnt_d  = shd_d;
                        act_d  = shd_d;
                        pend_d = 1'b0;
                        tgl_d  = 1'b0;
                    end else if (cnt_q == '0) begin
                        // Terminal count. A ratio write landing on this very
                        // edge is taken directly rather than deferred.
                        en_d   = 1'b1;
                        cnt_d  = shd_d;
                        act_d  = shd_d;
                        pend_d = 1'b0;
                        tgl_d  = tgl_mode_q[i] ? !tgl_q : 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        if (div_wr) begin
                            pend_d = 1'b1;
                        end
                        if (!tgl_mode_q[i]) begin
                            tgl_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d = CH_IDLE;
                end
            endcase
        end

        always_ff @(posedge mclk or posedge reset) begin
            if (reset) begin
                state_q <= CH_IDLE;
                cnt_q   <= '0;
                act_q   <= RATIO_RST;
                shd_q   <= RATIO_RST;
                pend_q  <= 1'b0;
                en_q    <= 1'b0;
                tgl_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                act_q   <= act_d;
                shd_q   <= shd_d;
                pend_q  <= pend_d;
                en_q    <= en_d;
                tgl_q   <= tgl_d;
            end
        end

        assign run_vec[i]  = (state_q == CH_RUN);
        assign pend_vec[i] = pend_q;
        assign shd_arr[i]  = shd_q;
        assign clk_en[i]   = en_q;
        assign clk_tgl[i]  = tgl_q;
    end

endmodule
